// File: rtl/hwpe_vfpu_pkg.sv
// Shared types and default sizes for the element-wise vector arithmetic engine.
package hwpe_vfpu_package;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_LEN_WIDTH  = 16;
  localparam int unsigned OP_WIDTH           = 3;

  typedef enum logic [OP_WIDTH-1:0] {
    VFPU_ADD = 3'd0,
    VFPU_SUB = 3'd1,
    VFPU_MUL = 3'd2,
    VFPU_MIN = 3'd3,
    VFPU_MAX = 3'd4
  } vfpu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } vfpu_state_e;

endpackage

// File: rtl/hwpe_vfpu_alu.sv
// Combinational integer op unit; unused encodings pass operand A through.
module hwpe_vfpu_alu
  import hwpe_vfpu_package::*;
#(
  parameter int unsigned DW = DEFAULT_DATA_WIDTH
) (
  input  logic [DW-1:0]       a_i,
  input  logic [DW-1:0]       b_i,
  input  logic [OP_WIDTH-1:0] op_i,
  output logic [DW-1:0]       res_o
);

  always_comb begin
    res_o = a_i;
    case (op_i)
      VFPU_ADD: res_o = a_i + b_i;
      VFPU_SUB: res_o = a_i - b_i;
      VFPU_MUL: res_o = a_i * b_i;
      VFPU_MIN: res_o = ($signed(a_i) < $signed(b_i)) ? a_i : b_i;
      VFPU_MAX: res_o = ($signed(a_i) < $signed(b_i)) ? b_i : a_i;
      default:  res_o = a_i;
    endcase
  end

endmodule

// File: rtl/hwpe_vfpu_engine.sv
// Streaming engine: joins A/B operand streams, applies one op per pair through
// a 2-stage elastic pipeline and emits a result stream for a fixed-length job.
module hwpe_vfpu_engine
  import hwpe_vfpu_package::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH  = DEFAULT_LEN_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic [OP_WIDTH-1:0]   op_i,
  input  logic                  a_valid_i,
  output logic                  a_ready_o,
  input  logic [DATA_WIDTH-1:0] a_data_i,
  input  logic                  b_valid_i,
  output logic                  b_ready_o,
  input  logic [DATA_WIDTH-1:0] b_data_i,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [LEN_WIDTH-1:0]  count_o
);

  vfpu_state_e           state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [LEN_WIDTH-1:0]  acc_q, acc_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0] s2_res_q, s2_res_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  s2_can_accept, s1_adv, s1_can_accept;
  logic                  join_fire, r_fire;
  logic [DATA_WIDTH-1:0] alu_res;

  hwpe_vfpu_alu #(.DW(DATA_WIDTH)) i_alu (
    .a_i   (s1_a_q),
    .b_i   (s1_b_q),
    .op_i  (op_q),
    .res_o (alu_res)
  );

  // Elastic handshakes: a stage moves when the one after it is empty or draining.
  assign r_fire        = s2_valid_q & r_ready_i;
  assign s2_can_accept = ~s2_valid_q | r_ready_i;
  assign s1_adv        = s1_valid_q & s2_can_accept;
  assign s1_can_accept = ~s1_valid_q | s1_adv;
  assign join_fire     = (state_q == ST_RUN) & a_valid_i & b_valid_i &
                         s1_can_accept & (acc_q < len_q);

  assign a_ready_o = join_fire;
  assign b_ready_o = join_fire;
  assign r_valid_o = s2_valid_q;
  assign r_data_o  = s2_res_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign count_o   = cnt_q;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    op_d       = op_q;
    acc_d      = acc_q + LEN_WIDTH'(join_fire);
    cnt_d      = cnt_q + LEN_WIDTH'(r_fire);
    s1_valid_d = join_fire ? 1'b1 : (s1_adv ? 1'b0 : s1_valid_q);
    s1_a_d     = join_fire ? a_data_i : s1_a_q;
    s1_b_d     = join_fire ? b_data_i : s1_b_q;
    s2_valid_d = s1_adv ? 1'b1 : (r_fire ? 1'b0 : s2_valid_q);
    s2_res_d   = s1_adv ? alu_res : s2_res_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          len_d   = len_i;
          op_d    = op_i;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = (len_i == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN:   if (acc_d == len_q) state_d = ST_DRAIN;
      ST_DRAIN: if (cnt_d == len_q) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase

    done_d = (state_d == ST_DONE);
    busy_d = (state_d == ST_RUN) | (state_d == ST_DRAIN);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      op_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      op_q       <= op_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_hwpe_vfpu_engine.sv
// Randomized self-checking bench for hwpe_vfpu_engine against a job-level reference model.
module tb_hwpe_vfpu_engine;

  localparam int unsigned DW = 32;
  localparam int unsigned LW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [LW-1:0] len_i;
  logic [2:0]    op_i;
  logic          a_valid_i, a_ready_o;
  logic [DW-1:0] a_data_i;
  logic          b_valid_i, b_ready_o;
  logic [DW-1:0] b_data_i;
  logic          r_valid_o, r_ready_i;
  logic [DW-1:0] r_data_o;
  logic          busy_o, done_o;
  logic [LW-1:0] count_o;

  hwpe_vfpu_engine dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i), .op_i(op_i),
    .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_data_i(a_data_i),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_data_i(b_data_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o),
    .busy_o(busy_o), .done_o(done_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          cyc = 0;

  // Job-level reference model
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_len = 0, m_acc = 0, m_emit = 0;
  logic [2:0]  m_op = 3'd0;
  logic [31:0] exp_q[$];

  // Stimulus sources and observation
  logic [31:0] qa[$], qb[$], obs_q[$];
  int          a_dly = 0, b_dly = 0, vld_pct = 100, rdy_pct = 100;
  bit          junk_valid = 1'b0;
  int          first_fire = -1, first_rv = -1, last_rfire = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd3: return ($signed(a) < $signed(b)) ? a : b;
      3'd4: return ($signed(a) > $signed(b)) ? a : b;
      default: return a;
    endcase
  endfunction

  // One clock: check handshakes, advance model on the edge, check registered outputs, drive.
  task automatic step();
    logic          pf, rf, st, rs, stalled, idle;
    logic [LW-1:0] sl;
    logic [2:0]    so;
    logic [31:0]   e, held;
    check("ready_join", 32'(a_ready_o), 32'(b_ready_o));
    check("ready_legal", 32'(a_ready_o && !(a_valid_i && b_valid_i && m_busy && (m_acc < m_len))), 32'd0);
    pf = a_ready_o && a_valid_i && b_valid_i;
    rf = r_valid_o && r_ready_i;
    if (r_valid_o && first_rv < 0) first_rv = cyc;
    if (pf && first_fire < 0) first_fire = cyc;
    if (rf) begin
      last_rfire = cyc;
      if (exp_q.size() == 0) check("r_spurious", 32'(r_valid_o), 32'd0);
      else begin
        e = exp_q.pop_front();
        check("r_data", r_data_o, e);
        obs_q.push_back(r_data_o);
      end
    end
    if (pf) exp_q.push_back(ref_op(m_op, a_data_i, b_data_i));
    st = start_i; rs = rst_i; sl = len_i; so = op_i;
    stalled = r_valid_o && !r_ready_i && !rs;
    held = r_data_o;

    @(posedge clk_i);
    cyc++;
    if (rs) begin
      m_busy = 1'b0; m_done = 1'b0; m_acc = 0; m_emit = 0;
      exp_q.delete(); qa.delete(); qb.delete();
    end else begin
      idle = !m_busy && !m_done;
      m_done = 1'b0;
      if (pf) begin
        m_acc++;
        if (qa.size() > 0) void'(qa.pop_front());
        if (qb.size() > 0) void'(qb.pop_front());
      end
      if (rf) begin
        m_emit++;
        if (m_busy && m_emit == m_len) begin m_busy = 1'b0; m_done = 1'b1; end
      end
      if (st && idle) begin
        m_len = int'(sl); m_op = so; m_acc = 0; m_emit = 0;
        if (sl == '0) m_done = 1'b1; else m_busy = 1'b1;
      end
    end

    @(negedge clk_i);
    check("busy", 32'(busy_o), 32'(m_busy));
    check("done", 32'(done_o), 32'(m_done));
    check("count", 32'(count_o), 32'(m_emit));
    check("inflight", 32'((m_acc - m_emit) <= 2), 32'd1);
    if (m_acc == m_emit) check("rvalid_empty", 32'(r_valid_o), 32'd0);
    if (stalled) begin
      check("stall_valid", 32'(r_valid_o), 32'd1);
      check("stall_data", r_data_o, held);
    end

    start_i = 1'b0;
    rst_i   = 1'b0;
    len_i   = LW'($urandom);
    op_i    = 3'($urandom);
    if (qa.size() > 0) begin
      if (a_valid_i && !pf && !rs) a_data_i = qa[0];
      else if (a_dly > 0) begin a_dly--; a_valid_i = 1'b0; a_data_i = $urandom; end
      else begin a_valid_i = ($urandom_range(0, 99) < vld_pct); a_data_i = qa[0]; end
    end else begin
      a_valid_i = junk_valid; a_data_i = $urandom;
    end
    if (qb.size() > 0) begin
      if (b_valid_i && !pf && !rs) b_data_i = qb[0];
      else if (b_dly > 0) begin b_dly--; b_valid_i = 1'b0; b_data_i = $urandom; end
      else begin b_valid_i = ($urandom_range(0, 99) < vld_pct); b_data_i = qb[0]; end
    end else begin
      b_valid_i = junk_valid; b_data_i = $urandom;
    end
    r_ready_i = ($urandom_range(0, 99) < rdy_pct);
    #1;
  endtask

  task automatic run_job(input int len, input int op, input int vp, input int rp,
                         input int ad, input int bd, input int bogus_at);
    int n;
    vld_pct = vp; rdy_pct = rp; a_dly = ad; b_dly = bd;
    obs_q.delete(); first_fire = -1; first_rv = -1; last_rfire = -1;
    start_i = 1'b1; len_i = LW'(len); op_i = 3'(op);
    step();
    n = 0;
    while ((m_busy || m_done) && n < 3000) begin
      if (n == bogus_at) begin start_i = 1'b1; len_i = LW'(2); op_i = 3'd0; end
      step();
      n++;
    end
    if (m_busy || m_done) check("job_timeout", 32'(n), 32'd0);
  endtask

  logic [31:0] add_exp[3];

  initial begin
    rst_i = 1'b1; start_i = 1'b0; len_i = '0; op_i = '0;
    a_valid_i = 1'b0; b_valid_i = 1'b0; a_data_i = '0; b_data_i = '0; r_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); #1;
    rst_i = 1'b1;
    step();
    check("reset_rvalid", 32'(r_valid_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_count", 32'(count_o), 32'd0);
    step();

    // ADD, latency and full throughput
    qa = '{32'd1, 32'd2, 32'd3}; qb = '{32'd10, 32'd20, 32'd30};
    run_job(3, 0, 100, 100, 0, 0, -1);
    add_exp = '{32'd11, 32'd22, 32'd33};
    check("add_nres", 32'(obs_q.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < obs_q.size()) check("add_res", obs_q[i], add_exp[i]);
    check("add_latency", 32'(first_rv - first_fire), 32'd2);
    check("add_throughput", 32'(last_rfire - first_fire), 32'd4);
    check("add_count", 32'(count_o), 32'd3);

    // Signed boundaries
    qa = '{32'h8000_0000}; qb = '{32'd1}; run_job(1, 1, 100, 100, 0, 0, -1);
    if (obs_q.size() > 0) check("sub_bound", obs_q[0], 32'h7FFF_FFFF); else check("sub_nres", 32'(obs_q.size()), 32'd1);
    qa = '{32'h8000_0000}; qb = '{32'd1}; run_job(1, 3, 100, 100, 0, 0, -1);
    if (obs_q.size() > 0) check("min_bound", obs_q[0], 32'h8000_0000); else check("min_nres", 32'(obs_q.size()), 32'd1);
    qa = '{32'h8000_0000}; qb = '{32'd1}; run_job(1, 4, 100, 100, 0, 0, -1);
    if (obs_q.size() > 0) check("max_bound", obs_q[0], 32'd1); else check("max_nres", 32'(obs_q.size()), 32'd1);
    qa = '{32'hFFFF_FFFF}; qb = '{32'd2}; run_job(1, 2, 100, 100, 0, 0, -1);
    if (obs_q.size() > 0) check("mul_bound", obs_q[0], 32'hFFFF_FFFE); else check("mul_nres", 32'(obs_q.size()), 32'd1);

    // Backpressure with an ignored start mid-job
    for (int i = 0; i < 8; i++) begin qa.push_back($urandom); qb.push_back($urandom); end
    run_job(8, 0, 100, 50, 0, 0, 3);
    check("bp_nres", 32'(obs_q.size()), 32'd8);
    check("bp_count", 32'(count_o), 32'd8);

    // Skewed B stream
    for (int i = 0; i < 4; i++) begin qa.push_back($urandom); qb.push_back($urandom); end
    run_job(4, 1, 100, 100, 0, 3, -1);
    check("skew_nres", 32'(obs_q.size()), 32'd4);

    // Zero-length job with valid inputs present
    junk_valid = 1'b1;
    run_job(0, 0, 100, 100, 0, 0, -1);
    check("len0_count", 32'(count_o), 32'd0);
    junk_valid = 1'b0;
    step();

    // Random jobs
    for (int j = 0; j < 10; j++) begin
      int len;
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        qa.push_back(($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom);
        qb.push_back(($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom);
      end
      run_job(len, $urandom_range(0, 7), $urandom_range(40, 100), $urandom_range(30, 100),
              $urandom_range(0, 2), $urandom_range(0, 2), -1);
      check("rnd_nres", 32'(obs_q.size()), 32'(len));
    end

    // Reset mid-job after two results
    for (int i = 0; i < 5; i++) begin qa.push_back(32'(i + 1)); qb.push_back(32'd100); end
    vld_pct = 100; rdy_pct = 100; a_dly = 0; b_dly = 0;
    start_i = 1'b1; len_i = LW'(5); op_i = 3'd0;
    step();
    for (int n = 0; n < 50 && m_emit < 2; n++) step();
    check("rst_pre_emit", 32'(m_emit), 32'd2);
    rst_i = 1'b1;
    step();
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_rvalid", 32'(r_valid_o), 32'd0);
    repeat (3) step();
    qa = '{32'd5}; qb = '{32'd6};
    run_job(1, 0, 100, 100, 0, 0, -1);
    if (obs_q.size() > 0) check("post_rst_res", obs_q[0], 32'd11); else check("post_rst_nres", 32'(obs_q.size()), 32'd1);
    check("post_rst_count", 32'(count_o), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hwpe_vfpu_engine.md
# hwpe_vfpu_engine

Streaming element-wise arithmetic engine between the source streamers, which feed operands A and B read from TCDM, and the sink streamer, which writes results back to TCDM. It joins two operand streams, applies one integer operation per element pair through a 2-stage elastic pipeline, and emits one result stream. The controller starts a job with a fixed element count and receives a done pulse once the last result has been handshaken downstream.

## Interface
- DATA_WIDTH, 32, element and stream width
- LEN_WIDTH, 16, width of job length and counters
- clk_i  in  1  clock
- rst_i  in  1  reset; **one clock, reset is synchronous and active-high**
- start_i  in  1  job start; sampled only in IDLE
- len_i  in  LEN_WIDTH  number of element pairs; latched on start
- op_i  in  3  operation select; latched on start
- a_valid_i / a_ready_o / a_data_i  in/out/in  1/1/DATA_WIDTH  operand A stream
- b_valid_i / b_ready_o / b_data_i  in/out/in  1/1/DATA_WIDTH  operand B stream
- r_valid_o / r_ready_i / r_data_o  out/in/out  1/1/DATA_WIDTH  result stream
- busy_o  out  1  high in RUN and DRAIN
- done_o  out  1  one-cycle pulse at job end
- count_o  out  LEN_WIDTH  results emitted in the current or last job

## Operation
- FSM states:
  - IDLE: start_i=1 latches len_i and op_i, clears both counters, then goes to RUN. If len_i=0, it goes to DONE instead.
  - RUN: accepts pairs until the accepted count equals len, then goes to DRAIN.
  - DRAIN: waits until the pipeline is empty and the emitted count equals len, then goes to DONE.
  - DONE: asserts done_o for 1 cycle, then goes to IDLE.
- Join: a_ready_o = b_ready_o = (state==RUN) & a_valid_i & b_valid_i & s1_can_accept & (accepted<len).
  - A pair is consumed only when both streams fire in the same cycle.
  - A lone valid on one stream is held and never consumed.
- Stage 1 registers the operands. Stage 2 computes and registers the result, which drives r_data_o.
  - Each stage advances when its downstream stage is empty or is being drained this cycle. This gives full throughput.
  - No ready-to-valid combinational path: r_valid_o depends only on registers.
- Operations (result is taken modulo 2^DATA_WIDTH):
  - 0 ADD: a+b
  - 1 SUB: a−b
  - 2 MUL: low DATA_WIDTH bits of a*b
  - 3 MIN: signed minimum
  - 4 MAX: signed maximum
  - 5–7: pass a
- count_o increments on each r_valid_o & r_ready_i, and keeps its value after done until the next start.
- start_i while busy is ignored; len_i and op_i changes mid-job have no effect.
- Reset:
  - State, counters, valid bits, done_o, busy_o and count_o go to 0 and the FSM goes to IDLE.
  - Data registers are don't-care, and r_data_o may be X-free zero.
  - A reset mid-job drops all in-flight data and does not pulse done.

## Timing
- Latency: a pair accepted at the clock edge t gives r_valid_o=1 from t+2 if the output is not stalled.
- Throughput: 1 pair per cycle when both inputs are valid and r_ready_i=1.
- Backpressure: with r_ready_i=0 the engine holds at most 2 results in flight, after which input readys drop.
  - r_valid_o and r_data_o stay stable until the handshake.
- done_o is asserted the cycle after the final result handshake. busy_o falls in that same cycle.
- len=0: done_o is asserted 1 cycle after start, with no stream activity.
- Counters are LEN_WIDTH wide. len=2^LEN_WIDTH−1 completes without wrapping.

## Structure
- Package hwpe_vfpu_package holds:
  - the op encoding enum (VFPU_ADD…VFPU_MAX)
  - the FSM state enum
  - the default DATA_WIDTH and LEN_WIDTH constants
- Sub-module hwpe_vfpu_alu is a combinational op unit (a, b, op → result), instantiated in stage 2.
- The FSM, join logic, pipeline registers and counters stay in the top module.

## Test plan
- ADD, len=3, A={1,2,3}, B={10,20,30}, r_ready_i=1 → R={11,22,33}; the first r_valid_o comes 2 cycles after the first accept; done_o is a single pulse; count_o=3.
- SUB/MIN/MAX signed boundaries: A=0x80000000, B=1 → SUB gives 0x7FFFFFFF; MIN gives 0x80000000; MAX gives 1. MUL 0xFFFF_FFFF*2 gives 0xFFFFFFFE.
- Backpressure, len=8, with r_ready_i toggled randomly at 50% → all 8 results arrive in order, never more than 2 in flight, and data is stable while stalled.
- Skewed inputs: B arrives 3 cycles after A → no element is consumed until both are valid; the results pair elements correctly.
- len=0 start → done_o is asserted the next cycle, both readys stay 0 and count_o=0. A start during busy is ignored.
- Reset asserted mid-job after 2 of 5 results → the FSM goes to IDLE and all flags are 0 with no done pulse. A new len=1 job then completes normally.
